// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths, default sizing and pointer-width helper for datapath FIFOs
package fifo_pkg;
    localparam int BYTE_W = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_AFULL_THRESH = 14;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/fifo8_ram.sv
// fifo8_ram: simple dual-port byte array with a registered read port, no reset
module fifo8_ram
    import fifo_pkg::*;
#(
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [BYTE_W-1:0] rdata
);
    logic [BYTE_W-1:0] mem [DEPTH];
    logic [BYTE_W-1:0] rdata_q;
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end
    assign rdata = rdata_q;
endmodule

// File: rtl/fifo8_sync.sv
// fifo8_sync: synchronous byte FIFO with registered read data, occupancy flags and error pulses
module fifo8_sync
    import fifo_pkg::*;
#(
    parameter int DEPTH        = FIFO_DEPTH,
    parameter int ADDR_W       = clog2(DEPTH),
    parameter int AFULL_THRESH = FIFO_AFULL_THRESH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] din,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);
    localparam int CNT_W = ADDR_W + 1;
    logic              wr_acc, rd_acc;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d, empty_q, empty_d, afull_q, afull_d;
    logic              valid_q, valid_d, ovf_q, ovf_d, udf_q, udf_d;
    logic              rd_seen_q, rd_seen_d;
    logic [BYTE_W-1:0] ram_rdata;
    always_comb begin
        wr_acc    = wr_en & ~full_q;
        rd_acc    = rd_en & ~empty_q;
        wr_ptr_d  = wr_acc ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d  = rd_acc ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d   = count_q + CNT_W'(wr_acc & ~rd_acc) - CNT_W'(rd_acc & ~wr_acc);
        full_d    = count_d == CNT_W'(DEPTH);
        empty_d   = count_d == '0;
        afull_d   = count_d >= CNT_W'(AFULL_THRESH);
        valid_d   = rd_acc;
        ovf_d     = wr_en & full_q;
        udf_d     = rd_en & empty_q;
        rd_seen_d = rd_seen_q | rd_acc;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            afull_q   <= 1'b0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            rd_seen_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            afull_q   <= afull_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            rd_seen_q <= rd_seen_d;
        end
    end
    fifo8_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (din),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );
    // RAM read register has no reset, so dout reads as zero until the first read after reset
    assign dout        = rd_seen_q ? ram_rdata : '0;
    assign dout_valid  = valid_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign almost_full = afull_q;
    assign count       = count_q;
    assign overflow    = ovf_q;
    assign underflow   = udf_q;
endmodule

// File: tb/tb_fifo8_sync.sv
// tb_fifo8_sync: queue-model scoreboard bench for fifo8_sync with directed and random traffic
module tb_fifo8_sync;
    typedef struct packed {
        logic [4:0] cnt;
        logic       fl, em, af, ov, un, dv;
        logic [7:0] dq;
    } stat_t;
    logic clk = 1'b0;
    logic rst, wr_en, rd_en;
    logic [7:0] din, dout;
    logic dout_valid, full, empty, almost_full, overflow, underflow;
    logic [4:0] count;
    int checks = 0;
    int errors = 0;
    logic [7:0] mdl[$];
    logic [7:0] dq[$];
    stat_t sq[$];
    logic [7:0] last_dout = 8'h00;

    fifo8_sync dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
        stat_t e;
        logic wa, ra;
        rst = r; wr_en = w; rd_en = rd; din = d;
        e = '0;
        if (r) begin
            mdl.delete();
            last_dout = 8'h00;
        end else begin
            wa = w && mdl.size() < 16;
            ra = rd && mdl.size() > 0;
            e.ov = w && mdl.size() == 16;
            e.un = rd && mdl.size() == 0;
            e.dv = ra;
            if (ra) begin
                last_dout = mdl.pop_front();
                dq.push_back(last_dout);
            end
            if (wa) mdl.push_back(d);
        end
        e.cnt = 5'(mdl.size());
        e.fl = mdl.size() == 16;
        e.em = mdl.size() == 0;
        e.af = mdl.size() >= 14;
        e.dq = last_dout;
        sq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sq.size() > 0) begin
            stat_t e;
            e = sq.pop_front();
            chk("count", 32'(count), 32'(e.cnt));
            chk("full", 32'(full), 32'(e.fl));
            chk("empty", 32'(empty), 32'(e.em));
            chk("almost_full", 32'(almost_full), 32'(e.af));
            chk("overflow", 32'(overflow), 32'(e.ov));
            chk("underflow", 32'(underflow), 32'(e.un));
            chk("dout_valid", 32'(dout_valid), 32'(e.dv));
            chk("dout_hold", 32'(dout), 32'(e.dq));
        end
        if (dout_valid) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read got %h expected none", dout);
            end else chk("read_data", 32'(dout), 32'(dq.pop_front()));
        end
    end

    initial begin
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        step(0, 1, 0, 8'h11);
        step(0, 1, 0, 8'h22);
        step(0, 1, 0, 8'h33);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(i));
        step(0, 1, 0, 8'hAA);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'(8'h40 + i));
        for (int i = 0; i < 40; i++) step(0, 1, 1, 8'(8'h44 + i));
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        step(0, 1, 1, 8'h5A);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 1, 0, 8'(8'h90 + i));
        step(1, 0, 0, 0);
        step(0, 1, 0, 8'hC3);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 63) == 0, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 2) != 0), 8'($urandom));
        for (int i = 0; i < 18; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("status_queue_drained", 32'(sq.size()), 32'd0);
        chk("data_queue_drained", 32'(dq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo8_sync.md
Name: fifo8_sync

Overview:
- Synchronous byte FIFO that buffers 8-bit words ahead of the 8-bit 2:1 data mux.
- Registered read data drives one mux input. dout_valid lets the downstream select logic switch the mux to the FIFO path for exactly the cycles that carry valid data.
- Single clock domain, no width conversion.

Parameters:
DEPTH, 16, number of 8-bit entries; must be a power of two, minimum 4
ADDR_W, 4, log2(DEPTH); pointer width
AFULL_THRESH, 14, count at or above which almost_full asserts; legal range 1..DEPTH-1

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
wr_en  input  1  write request
din  input  8  write data
rd_en  input  1  read request
dout  output  8  registered read data
dout_valid  output  1  one-cycle pulse: dout carries a freshly read word
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_THRESH
count  output  ADDR_W+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: wr_en while full, write dropped
underflow  output  1  one-cycle pulse: rd_en while empty, read dropped

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, rst.
- Reset values (rst high at a rising edge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, almost_full=0.
  - dout=8'h00, dout_valid=0, overflow=0, underflow=0.
  - Storage array is not reset.
- Reset mid-operation discards all contents. The first write after rst deasserts lands at address 0.
- Write accept: wr_acc = wr_en & ~full, using full as registered at the start of the cycle. On accept:
  - mem[wr_ptr] <= din
  - wr_ptr increments modulo DEPTH, wrapping from DEPTH-1 to 0.
- Read accept: rd_acc = rd_en & ~empty. On accept:
  - dout <= mem[rd_ptr]
  - rd_ptr increments modulo DEPTH
  - dout_valid <= 1 on the next edge.
  - Read latency is 1 cycle from the accepting edge.
- No read accepted: dout_valid <= 0 and dout holds its last value.
- Count update:
  - +1 on write-only accept.
  - -1 on read-only accept.
  - Unchanged when both or neither are accepted.
- full, empty and almost_full are registered and derived from the next-state count, so they are valid in the same cycle as the updated count.
- Simultaneous wr_en and rd_en:
  - Not empty and not full: both accepted, count unchanged.
  - Empty: write accepted, read rejected, underflow pulses. No write-through bypass; the data becomes readable the following cycle.
  - Full: read accepted, write rejected, overflow pulses. No same-cycle slot reuse.
- overflow and underflow are registered one-cycle pulses, asserted on the edge after the offending request. Pointers and count are unaffected.
- Read-during-write to the same address cannot occur: same address implies empty or full, and both cases are gated above.
- No state machine. Control state is wr_ptr, rd_ptr and count; all flags are registered.

Decomposition:
- Shared package fifo_pkg:
  - BYTE_W=8
  - clog2-style helper function or constant for ADDR_W
  - default DEPTH and AFULL_THRESH constants, shared with other FIFO instances in the datapath.
- One sub-module: fifo8_ram, a simple dual-port array.
  - Write port: we, waddr, wdata.
  - Registered read port: re, raddr, rdata.
  - No reset.
  - Kept separate so it can map to block or distributed RAM.
- Pointer, count and flag logic stays in fifo8_sync.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, dout=00, dout_valid=0 for 5 cycles.
- Write 8'h11, 8'h22, 8'h33 on consecutive cycles, then read 3 -> count goes 1,2,3 then 2,1,0. dout_valid pulses 3 cycles with dout 11,22,33, each appearing 1 cycle after its rd_en.
- Fill 16 words 00..0F -> almost_full high from count 14, full high at 16. A 17th write (8'hAA) pulses overflow, count stays 16. Draining returns 00..0F; 8'hAA never appears.
- Read while empty -> underflow pulse, dout_valid=0, dout unchanged, count stays 0.
- Prefill 4 words, then 40 cycles of simultaneous wr/rd with incrementing data -> count constant at 4, pointers wrap past 15→0, output order matches input order exactly.
- Empty FIFO with wr_en+rd_en same cycle (din=8'h5A) -> underflow pulse, count=1. Next-cycle read yields dout=5A with dout_valid.
- Mid-stream rst with count=9 -> next cycle count=0, empty=1. A subsequent write/read of 8'hC3 returns C3.
